// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 16x-oversampled UART receiver
//
// Recovers frames from the serial line using the shared baud tick s_tick
// (16 pulses per bit period). Frame format: one start bit, DBIT data bits
// LSB first, an optional even-parity bit, and a stop bit of SB_TICK ticks.
// Each completed frame updates dout / frame_err / parity_err and raises
// rx_done_tick for exactly one clk.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : PARITY state between DATA and STOP, even parity checked
//   undefined : start/data/stop only, parity_err tied to 0
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  s_tick count for the stop bit (16/24/32 = 1/1.5/2 stop bits)
//
// Ports:
//   clk           system clock
//   reset_n       synchronous active-low reset
//   s_tick        baud tick, one clk wide, 16 per bit period
//   rx            asynchronous serial line, idle high
//   rx_done_tick  one-cycle pulse: frame complete, dout valid
//   dout          last received data word
//   frame_err     stop bit sampled low on last frame
//   parity_err    parity mismatch on last frame
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [4:0]    S_MID    = 5'd7;
    localparam logic [4:0]    S_LAST   = 5'd15;
    localparam logic [4:0]    S_STOP   = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [4:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;
    logic [1:0]      rx_sync;
    logic            rx_s;

    // rx_sync[1] is the metastability-safe copy of the line, 2 clk behind rx
    assign rx_s = rx_sync[1];

`ifdef UART_RX_PARITY_EN
    logic par_bit;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            rx_sync      <= 2'b11;
            rx_done_tick <= 1'b0;
            dout         <= '0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_sync      <= {rx_sync[0], rx};
            rx_done_tick <= 1'b0;

            case (state)
                // Leaving IDLE does not wait for a tick; the falling edge
                // alone starts the start-bit timer.
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end

                // Re-check the line at mid start bit so short glitches
                // (or a stuck-low line after a bad stop bit) are rejected
                // unless still low here.
                START: begin
                    if (s_tick) begin
                        if (s == S_MID) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end

                // s is now aligned to mid-bit; every 16 ticks is the next
                // bit centre. Data arrives LSB first, so shift right.
                DATA: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            shift <= {rx_s, shift[DBIT-1:1]};
                            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s       <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
`endif

                // Results are committed together with the pulse; a bad stop
                // bit still delivers the word, only flagged.
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            state        <= IDLE;
                            s            <= '0;
                            dout         <= shift;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            // even parity: data XOR parity bit must be 0
                            parity_err   <= (^shift) ^ par_bit;
`endif
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
